read_pointer: RTL and testbench
===============================

READ_POINTER -- requirements
Module: read_pointer

Interface
REQ-001 Parameter SIZE, default 4: address width; depth 2**SIZE; pointers are SIZE+1 bits.
REQ-002 Parameter AE_LEVEL, default 2: almost-empty threshold in entries (used only with RD_ALMOST_EMPTY_EN).
REQ-003 r_clk  input  1: read-domain clock; all state on rising edge.
REQ-004 r_rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 r_en  input  1: read request from the consumer.
REQ-006 w_ptr  input  SIZE+1: write-domain Gray pointer, asynchronous to r_clk.
REQ-007 r_empty  output  1: FIFO empty, registered.
REQ-008 r_addr  output  SIZE: RAM read address, r_bin[SIZE-1:0].
REQ-009 r_ptr  output  SIZE+1: registered read Gray pointer, to write-domain synchronizer.
REQ-010 r_count  output  SIZE+1: registered occupancy seen by the read domain, 0..2**SIZE.
REQ-011 r_almost_empty  output  1: registered, r_count <= AE_LEVEL (macro-dependent).

Function
REQ-012 w_ptr SHALL pass through a 2-flop r_clk synchronizer; the second stage is s_wr_ptr; no other logic samples w_ptr.
REQ-013 Read accept = r_en & !r_empty; r_bin_nxt = r_bin + accept, modulo 2**(SIZE+1).
REQ-014 r_gray_nxt = r_bin_nxt ^ (r_bin_nxt >> 1); r_bin and r_ptr SHALL load r_bin_nxt and r_gray_nxt each cycle.
REQ-015 r_empty SHALL register (r_gray_nxt == s_wr_ptr); empty asserts in the same edge that accepts the last entry.
REQ-016 r_en while r_empty SHALL be ignored: no pointer change, no error output.
REQ-017 r_count SHALL register gray2bin(s_wr_ptr) - r_bin_nxt, SIZE+1 bits, wrap arithmetic.
REQ-018 Wrap-around: r_bin rollover from 2**(SIZE+1)-1 to 0 SHALL keep empty/count correct; r_addr wraps at 2**SIZE.
REQ-019 Write-to-visibility latency: w_ptr change reaches r_empty/r_count 3 r_clk edges later (2 sync + 1 flag register).
REQ-020 Simultaneous read accept and new s_wr_ptr in one cycle SHALL both be reflected in the next r_empty/r_count.
REQ-021 r_empty SHALL be conservative: never deasserted while the true FIFO is empty.

Reset
REQ-022 On r_rst_n low, immediately: r_bin=0, r_ptr=0, both sync stages=0, r_count=0, r_empty=1, r_almost_empty=1.
REQ-023 Reset mid-operation SHALL abandon state with no partial update; first read accept possible only after write data is synchronized.
REQ-024 Reset deassertion is synchronized externally to r_clk; the block adds no deassert synchronizer.

Configuration
REQ-025 Macro RD_ALMOST_EMPTY_EN defined: r_almost_empty registers (count_nxt <= AE_LEVEL), reset 1.
REQ-026 Macro undefined: r_almost_empty tied to r_empty; AE_LEVEL unused; all other behaviour identical.

Structure
REQ-027 Shared package fifo_pkg SHALL hold the SIZE default and bin2gray/gray2bin functions, shared with the write side.
REQ-028 One sub-module, sync_w2r (parameter WIDTH, 2-flop, async active-low reset to 0), SHALL implement REQ-012.
REQ-029 Binary-to-Gray conversion SHALL reuse the existing binary_to_gray module or the package function; no duplicate encoder.

Verification
REQ-030 Reset: assert r_rst_n=0 mid-cycle -> r_empty=1, r_ptr=0, r_addr=0, r_count=0 without waiting for a clock edge.
REQ-031 Latency: SIZE=4, w_ptr 0->1 at edge N -> r_empty=0, r_count=1 after edge N+3; r_en held 1 throughout -> exactly one accept, r_empty=1 again.
REQ-032 Drain: w_ptr=Gray(16), r_en=1 for 20 cycles -> 16 accepts, r_addr 0..15, r_count 16->0, r_empty=1 at 16th accept, pointers frozen after.
REQ-033 Wrap: 40 write/read pairs at full rate -> r_bin rolls past 31 to 0, r_ptr Gray single-bit steps, no false empty after first fill.
REQ-034 Almost-empty (macro on, AE_LEVEL=2): r_count 5->0 -> r_almost_empty rises at r_count=2, r_empty rises at 0; macro off -> r_almost_empty equals r_empty every cycle.
REQ-035 Underflow: r_en=1 with r_empty=1 for 10 cycles -> r_bin, r_ptr, r_count unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary pointer
// conversions, used by both the read-side and write-side pointer logic.
package fifo_pkg;

  localparam int FIFO_SIZE = 4;

  // Functions work on a fixed wide word; callers zero-extend and truncate with casts.
  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix-XOR from the MSB down, done as log2 shift/xor steps.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer carrying the write-domain Gray pointer into r_clk.
// Gray coding guarantees at most one bit is in flight per write.
module sync_w2r #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/read_pointer.sv
// Read-side pointer, empty flag and occupancy for an async Gray-pointer FIFO.
// Optional registered almost-empty flag enabled by macro RD_ALMOST_EMPTY_EN.
module read_pointer
  import fifo_pkg::*;
#(
  parameter int SIZE     = FIFO_SIZE,
  parameter int AE_LEVEL = 2
) (
  input  logic            r_clk,
  input  logic            r_rst_n,
  input  logic            r_en,
  input  logic [SIZE:0]   w_ptr,
  output logic            r_empty,
  output logic [SIZE-1:0] r_addr,
  output logic [SIZE:0]   r_ptr,
  output logic [SIZE:0]   r_count,
  output logic            r_almost_empty
);

  localparam int PW = SIZE + 1;

  logic [SIZE:0] s_wr_ptr;
  logic [SIZE:0] r_bin;
  logic [SIZE:0] r_bin_nxt;
  logic [SIZE:0] r_gray_nxt;
  logic [SIZE:0] wr_bin;
  logic [SIZE:0] count_nxt;
  logic          accept;

  sync_w2r #(
    .WIDTH (PW)
  ) u_sync_w2r (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .d     (w_ptr),
    .q     (s_wr_ptr)
  );

  // Handshake: a read is accepted on a rising edge where r_en=1 and r_empty=0;
  // r_en while empty is ignored and leaves every pointer unchanged.
  always_comb begin
    accept     = r_en & ~r_empty;
    r_bin_nxt  = r_bin + PW'(accept);
    r_gray_nxt = PW'(bin2gray(ptr_word_t'(r_bin_nxt)));
    wr_bin     = PW'(gray2bin(ptr_word_t'(s_wr_ptr)));
    count_nxt  = wr_bin - r_bin_nxt;
  end

  // Flags use the post-accept pointer so empty rises on the edge taking the last entry.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_empty <= 1'b1;
      r_count <= '0;
    end else begin
      r_bin   <= r_bin_nxt;
      r_ptr   <= r_gray_nxt;
      r_empty <= (r_gray_nxt == s_wr_ptr);
      r_count <= count_nxt;
    end
  end

  assign r_addr = r_bin[SIZE-1:0];

`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [SIZE:0] AE_THRESH = PW'(AE_LEVEL);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (count_nxt <= AE_THRESH);
    end
  end
`else
  assign r_almost_empty = r_empty;
`endif

endmodule

// File: tb/tb_read_pointer.sv
// Directed bench for read_pointer: reset, sync latency, drain, table-driven
// occupancy/wrap vectors, full-rate wrap, almost-empty and underflow.
module tb_read_pointer;

  localparam int SIZE = 4;
  localparam int PW   = SIZE + 1;
  localparam int AE   = 2;
`ifdef RD_ALMOST_EMPTY_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif

  logic            r_clk = 1'b0;
  logic            r_rst_n;
  logic            r_en;
  logic [SIZE:0]   w_ptr;
  logic            r_empty;
  logic [SIZE-1:0] r_addr;
  logic [SIZE:0]   r_ptr;
  logic [SIZE:0]   r_count;
  logic            r_almost_empty;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [PW-1:0] w_bin;
    logic          en;
    int            cycles;
    logic          exp_empty;
    logic [PW-1:0] exp_count;
    logic [PW-1:0] exp_rbin;
  } vec_t;

  vec_t vecs[13];

  // ---------------- clock / DUT ----------------
  always #5 r_clk = ~r_clk;

  read_pointer #(
    .SIZE     (SIZE),
    .AE_LEVEL (AE)
  ) dut (
    .r_clk          (r_clk),
    .r_rst_n        (r_rst_n),
    .r_en           (r_en),
    .w_ptr          (w_ptr),
    .r_empty        (r_empty),
    .r_addr         (r_addr),
    .r_ptr          (r_ptr),
    .r_count        (r_count),
    .r_almost_empty (r_almost_empty)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic exp_ae(input logic [PW-1:0] cnt, input logic emp);
    return AE_ON ? (cnt <= PW'(AE)) : emp;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic e_empty,
                             input logic [PW-1:0] e_count, input logic [PW-1:0] e_rbin);
    check({name, ".empty"}, 32'(r_empty), 32'(e_empty));
    check({name, ".count"}, 32'(r_count), 32'(e_count));
    check({name, ".ptr"},   32'(r_ptr),   32'(g(e_rbin)));
    check({name, ".addr"},  32'(r_addr),  32'(e_rbin[SIZE-1:0]));
    check({name, ".ae"},    32'(r_almost_empty), 32'(exp_ae(e_count, e_empty)));
  endtask

  task automatic do_reset();
    r_rst_n = 1'b0;
    r_en    = 1'b0;
    w_ptr   = '0;
    tick();
    tick();
    r_rst_n = 1'b1;
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int model_cnt;
    logic [PW-1:0] prev_ptr;

    vecs = '{
      '{5'd5,  1'b0, 4,  1'b0, 5'd5,  5'd0},
      '{5'd5,  1'b1, 2,  1'b0, 5'd3,  5'd2},
      '{5'd5,  1'b0, 2,  1'b0, 5'd3,  5'd2},
      '{5'd5,  1'b1, 5,  1'b1, 5'd0,  5'd5},
      '{5'd16, 1'b0, 4,  1'b0, 5'd11, 5'd5},
      '{5'd16, 1'b1, 11, 1'b1, 5'd0,  5'd16},
      '{5'd20, 1'b1, 3,  1'b0, 5'd4,  5'd16},
      '{5'd20, 1'b1, 1,  1'b0, 5'd3,  5'd17},
      '{5'd23, 1'b1, 3,  1'b0, 5'd3,  5'd20},
      '{5'd23, 1'b1, 4,  1'b1, 5'd0,  5'd23},
      '{5'd7,  1'b0, 3,  1'b0, 5'd16, 5'd23},
      '{5'd7,  1'b1, 16, 1'b1, 5'd0,  5'd7},
      '{5'd7,  1'b1, 10, 1'b1, 5'd0,  5'd7}
    };

    // Reset state, then no accept before the write pointer is synchronized
    do_reset();
    check_state("reset", 1'b1, 5'd0, 5'd0);
    w_ptr = g(5'd3);
    r_en  = 1'b1;
    tick(); tick();
    check_state("post_rst_e2", 1'b1, 5'd0, 5'd0);
    tick();
    check_state("post_rst_e3", 1'b0, 5'd3, 5'd0);
    tick();
    check_state("post_rst_acc", 1'b0, 5'd2, 5'd1);

    // Asynchronous reset mid-cycle, no clock edge needed
    #2;
    r_rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b1, 5'd0, 5'd0);
    w_ptr = '0;
    r_en  = 1'b0;
    tick();
    check_state("rst_hold", 1'b1, 5'd0, 5'd0);
    r_rst_n = 1'b1;

    // Write-to-visibility latency with r_en held high
    tick();
    w_ptr = g(5'd1);
    r_en  = 1'b1;
    tick(); tick();
    check_state("lat_n2", 1'b1, 5'd0, 5'd0);
    tick();
    check_state("lat_n3", 1'b0, 5'd1, 5'd0);
    tick();
    check_state("lat_acc", 1'b1, 5'd0, 5'd1);
    repeat (3) tick();
    check_state("lat_hold", 1'b1, 5'd0, 5'd1);

    // Drain a full FIFO; scoreboard holds the expected read addresses
    do_reset();
    w_ptr = g(5'd16);
    repeat (3) tick();
    check_state("drain_full", 1'b0, 5'd16, 5'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(PW'(i));
    model_cnt = 16;
    r_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (model_cnt != 0) begin
        check("drain_addr", 32'(r_addr), 32'(exp_q.pop_front()));
        model_cnt--;
      end
      tick();
      check("drain_count", 32'(r_count), 32'(model_cnt));
      check("drain_empty", 32'(r_empty), 32'(model_cnt == 0));
    end
    check_state("drain_end", 1'b1, 5'd0, 5'd16);

    // Almost-empty tracking while draining 5 entries
    do_reset();
    w_ptr = g(5'd5);
    repeat (3) tick();
    check_state("ae_start", 1'b0, 5'd5, 5'd0);
    r_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check_state("ae_drain", i == 0, PW'(i), PW'(5 - i));
    end

    // Table-driven occupancy, simultaneous update, wrap and underflow
    do_reset();
    for (int v = 0; v < 13; v++) begin
      w_ptr = g(vecs[v].w_bin);
      r_en  = vecs[v].en;
      repeat (vecs[v].cycles) tick();
      check_state($sformatf("vec%0d", v), vecs[v].exp_empty, vecs[v].exp_count, vecs[v].exp_rbin);
    end

    // Full-rate write/read pairs across the pointer rollover
    do_reset();
    r_en = 1'b1;
    prev_ptr = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      w_ptr = g(PW'(k));
      if (k >= 4) begin
        check_state("wrap_run", 1'b0, 5'd1, PW'(k - 4));
        check("wrap_step", 32'($countones(r_ptr ^ prev_ptr) <= 1), 32'd1);
      end
      prev_ptr = r_ptr;
    end
    repeat (8) tick();
    check_state("wrap_end", 1'b1, 5'd0, 5'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
